// File: rtl/encoder_pkg.sv
// encoder_pkg: shared constants for the quadrature-channel tick counter.
//   EDGE_RISE / EDGE_BOTH select the EDGE_MODE of encoder.
//   DEF_* hold the default WIDTH, SYNC_STAGES and FILTER_CYCLES.
//   Optional glitch filter is enabled by defining ENCODER_DEBOUNCE_EN.
`timescale 1ns/1ps
package encoder_pkg;
   localparam int EDGE_RISE         = 0;
   localparam int EDGE_BOTH         = 1;
   localparam int DEF_WIDTH         = 10;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_FILTER_CYCLES = 4;
endpackage

// File: rtl/encoder_sync_edge.sv
// encoder_sync_edge: synchronises the raw channel, optionally filters it, and
// detects its edges.
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   q_i     in   raw asynchronous encoder channel
//   rise_o  out  filtered channel rose this cycle
//   fall_o  out  filtered channel fell this cycle
// Macro ENCODER_DEBOUNCE_EN adds a FILTER_CYCLES-long glitch filter after the
// synchroniser; without it the synchronised value feeds the edge detector.
`timescale 1ns/1ps
module encoder_sync_edge
   import encoder_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic q_i,
   output logic rise_o,
   output logic fall_o
);
   if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
      $error("encoder_sync_edge: SYNC_STAGES must be >=2 and FILTER_CYCLES >=1");
   end
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   qs;
   logic                   qf;
   logic                   prev_q;
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], q_i};
   end
   assign qs = sync_q[SYNC_STAGES-1];
`ifdef ENCODER_DEBOUNCE_EN
   localparam int CW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
   logic [CW-1:0] run_q, run_d;
   logic          qf_q, qf_d;
   // run_q counts consecutive cycles of disagreement already seen; the
   // FILTER_CYCLES-th disagreeing cycle commits qs and restarts the run.
   always_comb begin
      run_d = '0;
      qf_d  = qf_q;
      if (qs != qf_q) begin
         if (run_q == CW'(FILTER_CYCLES - 1)) qf_d = qs;
         else                                 run_d = run_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q <= '0;
         qf_q  <= 1'b0;
      end else begin
         run_q <= run_d;
         qf_q  <= qf_d;
      end
   end
   assign qf = qf_q;
`else
   assign qf = qs;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= qf;
   end
   assign rise_o = qf & ~prev_q;
   assign fall_o = ~qf & prev_q;
endmodule

// File: rtl/encoder.sv
// encoder: counts edges of one quadrature-encoder channel into a wrapping tick count.
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset (wins over clr and edges)
//   q0     in   raw encoder channel, asynchronous
//   clr    in   synchronous count clear, drops a same-cycle event
//   TICKS  out  registered tick count, modulo 2^WIDTH
//   ovf    out  one-cycle pulse when TICKS wraps from all-ones to 0
// Macro ENCODER_DEBOUNCE_EN enables the glitch filter in encoder_sync_edge.
`timescale 1ns/1ps
module encoder
   import encoder_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int EDGE_MODE     = EDGE_RISE,
   parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             q0,
   input  logic             clr,
   output logic [WIDTH-1:0] TICKS,
   output logic             ovf
);
   logic             rise, fall, ev;
   logic [WIDTH-1:0] ticks_q, ticks_d;
   logic             ovf_q, ovf_d;
   encoder_sync_edge #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .q_i   (q0),
      .rise_o(rise),
      .fall_o(fall)
   );
   assign ev = (EDGE_MODE == EDGE_BOTH) ? (rise | fall) : rise;
   always_comb begin
      ticks_d = clr ? '0 : ev ? ticks_q + 1'b1 : ticks_q;
      ovf_d   = ~clr & ev & (&ticks_q);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ticks_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         ticks_q <= ticks_d;
         ovf_q   <= ovf_d;
      end
   end
   assign TICKS = ticks_q;
   assign ovf   = ovf_q;
endmodule

// File: tb/tb_encoder.sv
// tb_encoder: self-checking bench for encoder, one instance per EDGE_MODE.
`timescale 1ns/1ps
module tb_encoder;
   localparam int W  = 10;
   localparam int FC = 4;
`ifdef ENCODER_DEBOUNCE_EN
   localparam int D   = 3;
   localparam int PH  = FC + 2;
   localparam int LAT = 2 + FC;
`else
   localparam int D   = 2;
   localparam int PH  = 2;
   localparam int LAT = 2;
`endif
   logic clk = 0, rst_n = 0, q0 = 0, clr = 0;
   logic [W-1:0] t0, t1;
   logic o0, o1;
   encoder #(.EDGE_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .q0(q0), .clr(clr), .TICKS(t0), .ovf(o0));
   encoder #(.EDGE_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .q0(q0), .clr(clr), .TICKS(t1), .ovf(o1));
   always #0.5 clk = ~clk;
   typedef struct packed {
      logic [W-1:0] t0;
      logic         o0;
      logic [W-1:0] t1;
      logic         o1;
   } exp_t;
   exp_t expq[$];
   bit evq0[$], evq1[$];
   int n_chk = 0, n_pass = 0, nov0 = 0, nov1 = 0;
   logic [W-1:0] mc0, mc1;
   logic mo0, mo1, lv, fv;
   int run, lat, k;
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask
   task automatic upd(inout logic [W-1:0] mc, inout logic mo, input bit e, input logic c);
      if (c) begin
         mc = '0;
         mo = 1'b0;
      end else if (e) begin
         mo = (mc == '1);
         mc = mc + 1'b1;
      end else mo = 1'b0;
   endtask
   task automatic step(input logic q, input logic c, input logic r);
      exp_t e;
      bit rise, fall;
      @(negedge clk);
      q0 = q;
      clr = c;
      rst_n = ~r;
      if (r) begin
         mc0 = '0; mc1 = '0; mo0 = 0; mo1 = 0; lv = 0; fv = 0; run = 0;
         evq0 = {};
         evq1 = {};
         repeat (D) begin
            evq0.push_back(1'b0);
            evq1.push_back(1'b0);
         end
      end else begin
`ifdef ENCODER_DEBOUNCE_EN
         if (q != fv) begin
            if (run == FC - 1) begin
               fv = q;
               run = 0;
            end else run++;
         end else run = 0;
`else
         fv = q;
`endif
         rise = fv & ~lv;
         fall = ~fv & lv;
         lv = fv;
         evq0.push_back(rise);
         evq1.push_back(rise | fall);
         upd(mc0, mo0, evq0.pop_front(), c);
         upd(mc1, mo1, evq1.pop_front(), c);
      end
      expq.push_back('{mc0, mo0, mc1, mo1});
      @(posedge clk);
      #0.25;
      e = expq.pop_front();
      check("ticks_m0", t0, e.t0);
      check("ovf_m0", W'(o0), W'(e.o0));
      check("ticks_m1", t1, e.t1);
      check("ovf_m1", W'(o1), W'(e.o1));
      nov0 += int'(o0);
      nov1 += int'(o1);
   endtask
   task automatic pulses(input int n);
      repeat (n) begin
         repeat (PH) step(1, 0, 0);
         repeat (PH) step(0, 0, 0);
      end
   endtask
   initial begin
      // reset held while q0 toggles
      for (int i = 0; i < 5; i++) step(((i / 2) % 2) == 0, 0, 1);
      check("reset_ticks", t0, 0);
      // latency of the first rise after release
      repeat (2) step(0, 0, 0);
      lat = -1;
      for (int i = 0; i < LAT + PH + 2; i++) begin
         step(i < PH, 0, 0);
         if (lat < 0 && t0 == 1) lat = i;
      end
      check("latency", W'(lat), W'(LAT));
      // ten pulses in both edge modes
      step(0, 0, 1);
      repeat (2) step(0, 0, 0);
      pulses(10);
      repeat (LAT + 2) step(0, 0, 0);
      check("count_rise", t0, 10);
      check("count_both", t1, 20);
      // wrap
      step(0, 0, 1);
      step(0, 0, 0);
      nov0 = 0;
      nov1 = 0;
      pulses(1024);
      repeat (LAT + 2) step(0, 0, 0);
      check("wrap_ticks", t0, 0);
      check("wrap_ovf_n", W'(nov0), 1);
      check("wrap_ovf_n_m1", W'(nov1), 2);
      pulses(1);
      repeat (LAT + 2) step(0, 0, 0);
      check("wrap_plus1", t0, 1);
      check("wrap_plus1_ovf", W'(nov0), 1);
      // clear coinciding with a count event at TICKS=37
      step(0, 0, 1);
      k = 0;
      while (k < 4000 && !(mc0 == 37 && evq0[0])) begin
         step(((k / PH) % 2) == 0, 0, 0);
         k++;
      end
      check("pre_clr", t0, 37);
      step(((k / PH) % 2) == 0, 1, 0);
      k++;
      check("clr_ticks", t0, 0);
      step(((k / PH) % 2) == 0, 0, 0);
      check("clr_drop", t0, 0);
      // mid-run reset at TICKS=500
      k = 0;
      while (k < 20 * 1024 && mc0 != 500) begin
         step(((k / PH) % 2) == 0, 0, 0);
         k++;
      end
      check("pre_rst", t0, 500);
      step(0, 0, 1);
      check("midrst_ticks", t0, 0);
      step(0, 0, 0);
      pulses(3);
      repeat (LAT + 2) step(0, 0, 0);
      check("resume", t0, 3);
`ifdef ENCODER_DEBOUNCE_EN
      // short glitch filtered, long pulse counted with extra latency
      step(0, 0, 1);
      repeat (3) step(0, 0, 0);
      repeat (2) step(1, 0, 0);
      repeat (FC + 4) step(0, 0, 0);
      check("glitch", t0, 0);
      lat = -1;
      for (int i = 0; i < 16; i++) begin
         step(i < 6, 0, 0);
         if (lat < 0 && t0 == 1) lat = i;
      end
      check("db_latency", W'(lat), 6);
      check("db_count", t0, 1);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
